regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated scoreboard, for the pipelined MIPS core.
- Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. Register 0 is hard-wired to zero.
- Provides NUM_RD combinational read ports, with optional write-to-read bypass.
- Tracks a busy bit per register: set when a producer issues, cleared on writeback.
- Decode uses the busy flags to stall on RAW hazards and to refuse WAW issues.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_sb_scoreboard.sv | 59 +++++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with integrated scoreboard.
// Packed multi-port buses are sliced via port_lsb so all users agree on the layout.
package regfile_pkg;

    localparam int REG_ZERO       = 0;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    // Low bit index of port k within a packed bus of width-bit fields.
    function automatic int port_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking: reserves destinations on issue and releases them on
// writeback, refusing WAW issues and keeping a registered count of busy registers.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic                        iss_en,
    input  logic [ADDR_WIDTH-1:0]       iss_addr,
    output logic [(2**ADDR_WIDTH)-1:0]  busy,
    output logic                        iss_ok,
    output logic [ADDR_WIDTH:0]         busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [ADDR_WIDTH:0] cnt_r;
    logic [ADDR_WIDTH:0] cnt_nxt_s;
    logic              iss_ok_s;
    logic              dec_s;

    // Acceptance uses the pre-edge busy state; an accepted issue wins over a same-register clear.
    always_comb begin
        iss_ok_s   = iss_en && (iss_addr != ADDR_WIDTH'(REG_ZERO)) && !busy_r[iss_addr];
        dec_s      = wr_en && busy_r[wr_addr];
        busy_nxt_s = busy_r;
        for (int r = 0; r < DEPTH; r++) begin
            busy_nxt_s[r] = (iss_ok_s && (iss_addr == ADDR_WIDTH'(r))) ? 1'b1 :
                            ((wr_en && (wr_addr == ADDR_WIDTH'(r))) ? 1'b0 : busy_r[r]);
        end
        case ({iss_ok_s, dec_s})
            2'b10:   cnt_nxt_s = cnt_r + (ADDR_WIDTH+1)'(1);
            2'b01:   cnt_nxt_s = cnt_r - (ADDR_WIDTH+1)'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Busy vector and count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign iss_ok   = iss_ok_s;
    assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file (r0 hard-wired to zero) with optional write-to-read
// bypass and a busy-bit scoreboard used by decode for RAW stalls and WAW refusal.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic                         iss_ok,
    output logic [ADDR_WIDTH:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]      busy_s;

    regfile_sb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy_s),
        .iss_ok   (iss_ok),
        .busy_cnt (busy_cnt)
    );

    // Storage array; r0 is never written so its reads stay zero even without the read-side guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en && (wr_addr != ADDR_WIDTH'(REG_ZERO))) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic                  hit_s;
        logic [DATA_WIDTH-1:0] data_s;
        logic                  busy_k_s;

        assign addr_s = rd_addr[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign hit_s  = (BYPASS != 0) && wr_en && (wr_addr == addr_s);

        // Forwarded writeback data is already valid, so the port reports not-busy.
        always_comb begin
            if (addr_s == ADDR_WIDTH'(REG_ZERO)) begin
                data_s   = {DATA_WIDTH{1'b0}};
                busy_k_s = 1'b0;
            end else if (hit_s) begin
                data_s   = wr_data;
                busy_k_s = 1'b0;
            end else begin
                data_s   = regs_r[addr_s];
                busy_k_s = busy_s[addr_s];
            end
        end

        assign rd_data[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = data_s;
        assign rd_busy[k]                                     = busy_k_s;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus;
// expectations are queued as stimulus is driven and checked once outputs settle.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic        b_iss_ok;
    logic [5:0]  b_busy_cnt;
    logic [63:0] n_rd_data;
    logic [1:0]  n_rd_busy;
    logic        n_iss_ok;
    logic [5:0]  n_busy_cnt;

    int tests_run;
    int tests_failed;

    string       q_tag [$];
    int          q_sel [$];
    logic [31:0] q_exp [$];

    localparam int S_D0 = 0, S_D1 = 1, S_B0 = 2, S_B1 = 3, S_CNT = 4, S_OK = 5;
    localparam int S_ND1 = 6, S_NB1 = 7, S_NCNT = 8;

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ok(b_iss_ok), .busy_cnt(b_busy_cnt)
    );

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .iss_ok(n_iss_ok), .busy_cnt(n_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
    endtask

    task automatic drain();
        string       tag;
        int          sel;
        logic [31:0] exp;
        logic [31:0] obs;
        while (q_sel.size() > 0) begin
            tag = q_tag.pop_front();
            sel = q_sel.pop_front();
            exp = q_exp.pop_front();
            case (sel)
                S_D0:    obs = b_rd_data[31:0];
                S_D1:    obs = b_rd_data[63:32];
                S_B0:    obs = {31'd0, b_rd_busy[0]};
                S_B1:    obs = {31'd0, b_rd_busy[1]};
                S_CNT:   obs = {26'd0, b_busy_cnt};
                S_OK:    obs = {31'd0, b_iss_ok};
                S_ND1:   obs = n_rd_data[63:32];
                S_NB1:   obs = {31'd0, n_rd_busy[1]};
                S_NCNT:  obs = {26'd0, n_busy_cnt};
                default: obs = 32'hxxxx_xxxx;
            endcase
            check_val(tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs away from the rising edge and let combinational outputs settle.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        rst      = r;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = {a1, a0};
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0; rd_addr = 10'd0;

        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Reset state
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd5);
        expect_val("rst_d_r1", S_D0, 32'd0);
        expect_val("rst_d_r5", S_D1, 32'd0);
        expect_val("rst_b_r1", S_B0, 32'd0);
        expect_val("rst_b_r5", S_B1, 32'd0);
        expect_val("rst_cnt", S_CNT, 32'd0);
        expect_val("rst_nb_cnt", S_NCNT, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd31, 5'd31);
        expect_val("rst_d_r31", S_D0, 32'd0);
        expect_val("rst_b_r31", S_B1, 32'd0);
        drain();

        // Write then read
        drive(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_rd_during_wr", S_D0, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        expect_val("r7_p0", S_D0, 32'hDEADBEEF);
        expect_val("r7_p1", S_D1, 32'hDEADBEEF);
        expect_val("r7_nb_p1", S_ND1, 32'hDEADBEEF);
        drain();
        drive(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_no_fwd", S_D0, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_after_wr", S_D0, 32'd0);
        drain();

        // Bypass vs stored value
        drive(1'b0, 1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 5'd0, 5'd3);
        expect_val("byp_first", S_D1, 32'h1111);
        expect_val("nob_first", S_ND1, 32'd0);
        drain();
        drive(1'b0, 1'b1, 5'd3, 32'hA5A5, 1'b0, 5'd0, 5'd3, 5'd3);
        expect_val("byp_a5a5", S_D1, 32'hA5A5);
        expect_val("nob_old", S_ND1, 32'h1111);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        expect_val("nob_stored", S_ND1, 32'hA5A5);
        drain();

        // RAW scoreboard
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
        expect_val("iss9_ok", S_OK, 32'd1);
        expect_val("iss9_b_same", S_B0, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_val("r9_busy", S_B0, 32'd1);
        expect_val("r9_cnt1", S_CNT, 32'd1);
        expect_val("r9_nb_busy", S_NB1, 32'd1);
        drain();
        drive(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_val("r9_wb_busy", S_B0, 32'd0);
        expect_val("r9_wb_data", S_D0, 32'h55);
        expect_val("r9_wb_nb_busy", S_NB1, 32'd1);
        expect_val("r9_wb_nb_data", S_ND1, 32'd0);
        expect_val("r9_wb_cnt", S_CNT, 32'd1);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_val("r9_cnt0", S_CNT, 32'd0);
        expect_val("r9_free", S_B0, 32'd0);
        expect_val("r9_data", S_D0, 32'h55);
        drain();

        // WAW and simultaneous events
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
        expect_val("iss4_ok", S_OK, 32'd1);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
        expect_val("waw_refused", S_OK, 32'd0);
        expect_val("waw_cnt1", S_CNT, 32'd1);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        expect_val("waw_cnt_hold", S_CNT, 32'd1);
        drain();
        drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd4);
        expect_val("sim_refused", S_OK, 32'd0);
        expect_val("sim_fwd_busy", S_B0, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd4);
        expect_val("sim_cnt0", S_CNT, 32'd0);
        expect_val("sim_b4_clear", S_B0, 32'd0);
        expect_val("retry_ok", S_OK, 32'd1);
        expect_val("sim_data", S_D0, 32'h44);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, 5'd4);
        expect_val("iss_r0_ok", S_OK, 32'd0);
        expect_val("retry_cnt1", S_CNT, 32'd1);
        expect_val("retry_busy", S_B0, 32'd1);
        drain();
        drive(1'b0, 1'b1, 5'd4, 32'h45, 1'b1, 5'd11, 5'd4, 5'd4);
        expect_val("iss11_ok", S_OK, 32'd1);
        drain();
        drive(1'b0, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 5'd12, 5'd11);
        expect_val("iss12_ok", S_OK, 32'd1);
        expect_val("swap_cnt_before", S_CNT, 32'd1);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd11);
        expect_val("swap_cnt_same", S_CNT, 32'd1);
        expect_val("r12_busy", S_B0, 32'd1);
        expect_val("r11_free", S_B1, 32'd0);
        drain();
        drive(1'b0, 1'b1, 5'd12, 32'hCC, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_val("drain_cnt0", S_CNT, 32'd0);
        drain();

        // Reset mid-operation
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd6);
        expect_val("mid_cnt3", S_CNT, 32'd3);
        expect_val("mid_b2", S_B0, 32'd1);
        expect_val("mid_b6", S_B1, 32'd1);
        drain();
        drive(1'b1, 1'b1, 5'd3, 32'h99, 1'b1, 5'd5, 5'd2, 5'd6);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd5);
        expect_val("post_cnt0", S_CNT, 32'd0);
        expect_val("post_b10", S_B0, 32'd0);
        expect_val("post_b5", S_B1, 32'd0);
        drain();
        drive(1'b0, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 5'd7, 5'd3);
        expect_val("post_r7_clr", S_D0, 32'd0);
        expect_val("post_r3_clr", S_D1, 32'd0);
        drain();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd6);
        expect_val("post_r6_data", S_D0, 32'h77);
        expect_val("post_r6_busy", S_B1, 32'd0);
        expect_val("post_wb_cnt0", S_CNT, 32'd0);
        expect_val("post_nb_r6", S_ND1, 32'h77);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
